// File: rtl/addrunit_queued.sv
// Queued address-generation unit. Ops from the reservation station have their
// effective address computed on entry, wait in a small in-order FIFO, and
// leave at the head. Aligned loads go to the load buffer over valid/ready.
// Stores and misaligned loads leave without a handshake. Every op that leaves
// is reported to the ROB with its EA.
module addrunit_queued #(
  parameter int ID_WIDTH    = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ROB_WIDTH   = 4,
  parameter int OPC_WIDTH   = 6,
  parameter int DEPTH       = 4,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rs_agu_valid_in,
  output logic                  rs_agu_ready_out,
  input  logic [ID_WIDTH-1:0]   rs_agu_a_in,
  input  logic [ID_WIDTH-1:0]   rs_agu_vj_in,
  input  logic [ROB_WIDTH-1:0]  rs_agu_dest_in,
  input  logic [OPC_WIDTH-1:0]  rs_agu_opcode_in,
  input  logic                  rs_agu_is_load_in,
  input  logic [1:0]            rs_agu_size_in,
  output logic                  agu_lbuffer_valid_out,
  input  logic                  lbuffer_agu_ready_in,
  output logic [ADDR_WIDTH-1:0] agu_lbuffer_a_out,
  output logic [ROB_WIDTH-1:0]  agu_lbuffer_dest_out,
  output logic [OPC_WIDTH-1:0]  agu_lbuffer_opcode_out,
  input  logic                  rob_agu_rst_in,
  output logic                  agu_rob_en_out,
  output logic [ROB_WIDTH-1:0]  agu_rob_h_out,
  output logic [ADDR_WIDTH-1:0] agu_rob_address_out,
  output logic                  agu_rob_misalign_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] ea;
    logic [ROB_WIDTH-1:0]  dest;
    logic [OPC_WIDTH-1:0]  opcode;
    logic                  is_load;
    logic                  mis;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             new_entry;
  entry_t             head;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               full_q;
  logic               ready_int;
  logic               active;
  logic               not_empty;
  logic               enq;
  logic               deq;
  logic               lb_valid;
  logic [ID_WIDTH-1:0] sum;

  // EA and misalignment flag of the incoming op, computed once at entry.
  always_comb begin
    sum              = rs_agu_vj_in + rs_agu_a_in;
    new_entry        = '0;
    new_entry.ea     = sum[ADDR_WIDTH-1:0];
    new_entry.dest   = rs_agu_dest_in;
    new_entry.opcode = rs_agu_opcode_in;
    new_entry.is_load = rs_agu_is_load_in;
    if (CHECK_ALIGN) begin
      if (rs_agu_size_in == 2'd1)
        new_entry.mis = new_entry.ea[0];
      else if (rs_agu_size_in[1])
        new_entry.mis = (new_entry.ea[1:0] != 2'b00);
    end
  end

  // Handshake decisions for this cycle; a flush masks both sides.
  always_comb begin
    head      = mem[rd_ptr];
    active    = rdy_in & ~rob_agu_rst_in;
    not_empty = (count != '0);
    ready_int = rdy_in & ~full_q;
    enq       = rs_agu_valid_in & ready_int & ~rob_agu_rst_in;
    lb_valid  = active & not_empty & head.is_load & ~head.mis;
    deq       = active & not_empty &
                (~head.is_load | head.mis | lbuffer_agu_ready_in);
    count_next = count;
    if (enq && !deq)
      count_next = count + 1'b1;
    else if (!enq && deq)
      count_next = count - 1'b1;
  end

  // Entry storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk_in) begin
    if (enq)
      mem[wr_ptr] <= new_entry;
  end

  // Pointers, occupancy and the registered full flag behind ready.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else if (rdy_in) begin
      if (rob_agu_rst_in) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        full_q <= 1'b0;
      end else begin
        if (enq)
          wr_ptr <= wr_ptr + 1'b1;
        if (deq)
          rd_ptr <= rd_ptr + 1'b1;
        count  <= count_next;
        full_q <= (count_next == CNT_W'(DEPTH));
      end
    end
  end

  // Output ports; payloads are zeroed whenever their qualifier is low.
  always_comb begin
    rs_agu_ready_out       = ready_int & ~rst_in;
    agu_lbuffer_valid_out  = lb_valid;
    agu_lbuffer_a_out      = lb_valid ? head.ea : '0;
    agu_lbuffer_dest_out   = lb_valid ? head.dest : '0;
    agu_lbuffer_opcode_out = lb_valid ? head.opcode : '0;
    agu_rob_en_out         = deq;
    agu_rob_h_out          = deq ? head.dest : '0;
    agu_rob_address_out    = deq ? head.ea : '0;
    agu_rob_misalign_out   = deq & head.mis;
  end

endmodule

// File: tb/tb_addrunit_queued.sv
// Bench for addrunit_queued: directed scenarios plus random traffic, all
// checked against a queue-based model of the unit's documented behaviour.
module tb_addrunit_queued;

  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_vj = '0;
  logic [3:0]  op_dest = '0;
  logic [5:0]  op_opc = '0;
  logic        op_ld = 1'b0;
  logic [1:0]  op_size = '0;
  logic        lb_ready = 1'b0;
  logic        flush = 1'b0;

  logic        d1_ready, d1_lbv, d1_en, d1_mis;
  logic [31:0] d1_lba, d1_addr;
  logic [3:0]  d1_lbdest, d1_h;
  logic [5:0]  d1_lbopc;
  logic        d2_ready, d2_lbv, d2_en, d2_mis;
  logic [31:0] d2_lba, d2_addr;
  logic [3:0]  d2_lbdest, d2_h;
  logic [5:0]  d2_lbopc;
  logic [81:0] obs1;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  addrunit_queued #(.DEPTH(DEPTH), .CHECK_ALIGN(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rs_agu_valid_in(valid), .rs_agu_ready_out(d1_ready),
    .rs_agu_a_in(op_a), .rs_agu_vj_in(op_vj), .rs_agu_dest_in(op_dest),
    .rs_agu_opcode_in(op_opc), .rs_agu_is_load_in(op_ld), .rs_agu_size_in(op_size),
    .agu_lbuffer_valid_out(d1_lbv), .lbuffer_agu_ready_in(lb_ready),
    .agu_lbuffer_a_out(d1_lba), .agu_lbuffer_dest_out(d1_lbdest),
    .agu_lbuffer_opcode_out(d1_lbopc), .rob_agu_rst_in(flush),
    .agu_rob_en_out(d1_en), .agu_rob_h_out(d1_h),
    .agu_rob_address_out(d1_addr), .agu_rob_misalign_out(d1_mis)
  );

  addrunit_queued #(.DEPTH(DEPTH), .CHECK_ALIGN(1'b0)) dut_noalign (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rs_agu_valid_in(valid), .rs_agu_ready_out(d2_ready),
    .rs_agu_a_in(op_a), .rs_agu_vj_in(op_vj), .rs_agu_dest_in(op_dest),
    .rs_agu_opcode_in(op_opc), .rs_agu_is_load_in(op_ld), .rs_agu_size_in(op_size),
    .agu_lbuffer_valid_out(d2_lbv), .lbuffer_agu_ready_in(lb_ready),
    .agu_lbuffer_a_out(d2_lba), .agu_lbuffer_dest_out(d2_lbdest),
    .agu_lbuffer_opcode_out(d2_lbopc), .rob_agu_rst_in(flush),
    .agu_rob_en_out(d2_en), .agu_rob_h_out(d2_h),
    .agu_rob_address_out(d2_addr), .agu_rob_misalign_out(d2_mis)
  );

  assign obs1 = {d1_ready, d1_lbv, d1_lba, d1_lbdest, d1_lbopc,
                 d1_en, d1_h, d1_addr, d1_mis};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] ea;
    logic [3:0]  dest;
    logic [5:0]  opc;
    logic        is_load;
    logic        mis;
  } op_t;

  op_t q[$];
  bit  m_full = 1'b0;

  function automatic bit m_ready();
    return !rst_in && rdy_in && !m_full;
  endfunction

  function automatic op_t m_head();
    op_t h = '0;
    if (q.size() > 0) h = q[0];
    return h;
  endfunction

  function automatic bit m_active();
    return rdy_in && !rst_in && !flush && q.size() > 0;
  endfunction

  function automatic bit m_en();
    op_t h = m_head();
    return m_active() && (!h.is_load || h.mis || lb_ready);
  endfunction

  function automatic logic [81:0] exp_vec();
    op_t  h = m_head();
    logic lbv = m_active() && h.is_load && !h.mis;
    logic en  = m_en();
    return {m_ready(), lbv, lbv ? h.ea : 32'h0, lbv ? h.dest : 4'h0,
            lbv ? h.opc : 6'h0, en, en ? h.dest : 4'h0, en ? h.ea : 32'h0,
            en && h.mis};
  endfunction

  function automatic op_t m_new();
    op_t e;
    e.ea      = op_vj + op_a;
    e.dest    = op_dest;
    e.opc     = op_opc;
    e.is_load = op_ld;
    e.mis     = (op_size == 2'd1 && (e.ea % 2) != 0) ||
                (op_size >= 2'd2 && (e.ea % 4) != 0);
    return e;
  endfunction

  // Apply this cycle's inputs to the model, then advance to just past the edge.
  task automatic tick();
    bit acc, d;
    if (rst_in) begin
      q.delete();
      m_full = 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        q.delete();
        m_full = 1'b0;
      end else begin
        acc = valid && m_ready();
        d   = m_en();
        if (d) void'(q.pop_front());
        if (acc) q.push_back(m_new());
        m_full = (q.size() == DEPTH);
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_op(input bit v, input bit ld, input logic [1:0] sz,
                        input logic [31:0] vj, input logic [31:0] a,
                        input logic [3:0] dest, input logic [5:0] opc);
    valid = v; op_ld = ld; op_size = sz; op_vj = vj; op_a = a;
    op_dest = dest; op_opc = opc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #3;
    checks++;
    if (obs1 !== 82'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", obs1);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", obs1, exp_vec());
    end
    tick();
  endtask

  task automatic test_basic_load();
    lb_ready = 1'b1;
    set_op(1, 1, 2'd2, 32'h1000, 32'h10, 4'd5, 6'h2A);
    #2;
    checks++;
    if (obs1 !== exp_vec()) begin
      failures++; $display("FAIL basic_enq got=%h exp=%h", obs1, exp_vec());
    end
    tick();
    valid = 1'b0;
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_lbv !== 1'b1 || d1_lba !== 32'h1010 ||
        d1_en !== 1'b1 || d1_h !== 4'd5 || d1_mis !== 1'b0 || d1_lbopc !== 6'h2A) begin
      failures++; $display("FAIL basic_load got=%h exp=%h", obs1, exp_vec());
    end
    tick();
  endtask

  task automatic test_stall();
    lb_ready = 1'b0;
    set_op(1, 1, 2'd2, 32'h2000, 32'h4, 4'd7, 6'h11);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (obs1 !== exp_vec() || d1_lbv !== 1'b1 || d1_lba !== 32'h2004 ||
          d1_lbdest !== 4'd7 || d1_en !== 1'b0) begin
        failures++; $display("FAIL stall_hold cyc%0d got=%h exp=%h", i, obs1, exp_vec());
      end
      tick();
    end
    lb_ready = 1'b1;
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_en !== 1'b1 || d1_h !== 4'd7) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", obs1, exp_vec());
    end
    tick();
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_en !== 1'b0 || d1_lbv !== 1'b0) begin
      failures++; $display("FAIL stall_empty got=%h exp=%h", obs1, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] order[$];
    bit acc;
    int idx = 0;
    order = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    #1;
    lb_ready = 1'b0;
    set_op(1, 1, 2'd2, 32'h3000, 32'h0, 4'd1, 6'h01);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_op(1, 0, 2'd2, 32'h4000 + 32'(k * 16), 32'h8, 4'(k + 2), 6'h02);
      acc = 1'b0;
      for (int w = 0; w < 12 && !acc; w++) begin
        if (w >= 3) lb_ready = 1'b1;
        #2;
        checks++;
        if (obs1 !== exp_vec()) begin
          failures++; $display("FAIL b2b_fill op%0d w%0d got=%h exp=%h", k, w, obs1, exp_vec());
        end
        if (d1_en === 1'b1) begin
          checks++;
          if (idx >= order.size() || d1_h !== order[idx]) begin
            failures++; $display("FAIL b2b_order got=%0d idx=%0d", d1_h, idx);
          end
          idx++;
        end
        acc = m_ready() && valid;
        tick();
      end
      if (!acc) begin
        checks++; failures++;
        $display("FAIL b2b_timeout op%0d got=stuck exp=accepted", k);
      end
    end
    valid = 1'b0;
    lb_ready = 1'b1;
    for (int w = 0; w < 10 && q.size() > 0; w++) begin
      #2;
      checks++;
      if (obs1 !== exp_vec()) begin
        failures++; $display("FAIL b2b_drain w%0d got=%h exp=%h", w, obs1, exp_vec());
      end
      if (d1_en === 1'b1) begin
        checks++;
        if (idx >= order.size() || d1_h !== order[idx]) begin
          failures++; $display("FAIL b2b_order got=%0d idx=%0d", d1_h, idx);
        end
        idx++;
      end
      tick();
    end
    checks++;
    if (idx != 5) begin
      failures++; $display("FAIL b2b_count got=%0d exp=5", idx);
    end
  endtask

  task automatic test_misalign();
    valid = 1'b0;
    flush = 1'b1;
    #2;
    tick();
    flush = 1'b0;
    lb_ready = 1'b1;
    set_op(1, 1, 2'd1, 32'h1000, 32'h3, 4'd9, 6'h05);
    #2;
    tick();
    valid = 1'b0;
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_lbv !== 1'b0 || d1_en !== 1'b1 ||
        d1_mis !== 1'b1 || d1_addr !== 32'h1003) begin
      failures++; $display("FAIL misalign_flag got=%h exp=%h", obs1, exp_vec());
    end
    checks++;
    if (d2_lbv !== 1'b1 || d2_lba !== 32'h1003 || d2_en !== 1'b1 ||
        d2_mis !== 1'b0 || d2_h !== 4'd9) begin
      failures++;
      $display("FAIL noalign_send got=v%b a%h en%b m%b exp=v1 a00001003 en1 m0",
               d2_lbv, d2_lba, d2_en, d2_mis);
    end
    tick();
  endtask

  task automatic test_flush();
    lb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_op(1, 1, 2'd2, 32'h5000, 32'(k * 4), 4'(k + 10), 6'h03);
      tick();
    end
    set_op(1, 0, 2'd2, 32'h6000, 32'h0, 4'd14, 6'h04);
    flush = 1'b1;
    lb_ready = 1'b1;
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_lbv !== 1'b0 || d1_en !== 1'b0) begin
      failures++; $display("FAIL flush_cycle got=%h exp=%h", obs1, exp_vec());
    end
    tick();
    flush = 1'b0;
    valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (obs1 !== exp_vec() || d1_ready !== 1'b1 || d1_lbv !== 1'b0 || d1_en !== 1'b0) begin
        failures++; $display("FAIL flush_after cyc%0d got=%h exp=%h", i, obs1, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_wrap_freeze();
    lb_ready = 1'b0;
    set_op(1, 1, 2'd2, 32'hFFFF_FFFC, 32'h8, 4'd3, 6'h06);
    tick();
    set_op(1, 0, 2'd2, 32'h40, 32'h4, 4'd4, 6'h07);
    tick();
    rdy_in = 1'b0;
    lb_ready = 1'b1;
    set_op(1, 0, 2'd0, 32'h80, 32'h1, 4'd15, 6'h08);
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (obs1 !== 82'h0 || obs1 !== exp_vec()) begin
        failures++; $display("FAIL freeze cyc%0d got=%h exp=0", i, obs1);
      end
      tick();
    end
    rdy_in = 1'b1;
    valid = 1'b0;
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_lba !== 32'h4 || d1_en !== 1'b1 || d1_h !== 4'd3) begin
      failures++; $display("FAIL wrap_load got=%h exp=%h", obs1, exp_vec());
    end
    tick();
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_en !== 1'b1 || d1_h !== 4'd4 ||
        d1_addr !== 32'h44 || d1_lbv !== 1'b0) begin
      failures++; $display("FAIL resume_store got=%h exp=%h", obs1, exp_vec());
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rdy_in   = ($urandom_range(0, 7) != 0);
      flush    = rdy_in && ($urandom_range(0, 31) == 0);
      lb_ready = ($urandom_range(0, 2) != 0);
      set_op($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
             $urandom(), 32'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             6'($urandom_range(0, 63)));
      #2;
      checks++;
      if (obs1 !== exp_vec()) begin
        failures++; $display("FAIL random cyc%0d got=%h exp=%h", i, obs1, exp_vec());
      end
      tick();
    end
    rdy_in = 1'b1;
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    lb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_op(1, 1, 2'd2, 32'h7000, 32'(k * 8), 4'(k + 1), 6'h09);
      tick();
    end
    valid = 1'b0;
    #2;
    rst_in = 1'b1;
    q.delete();
    m_full = 1'b0;
    #1;
    checks++;
    if (obs1 !== 82'h0 || obs1 !== exp_vec()) begin
      failures++; $display("FAIL async_reset got=%h exp=0", obs1);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    lb_ready = 1'b1;
    #2;
    checks++;
    if (obs1 !== exp_vec() || d1_ready !== 1'b1 || d1_en !== 1'b0) begin
      failures++; $display("FAIL async_reset_after got=%h exp=%h", obs1, exp_vec());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_back_to_back();
    test_misalign();
    test_flush();
    test_wrap_freeze();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
